mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/wait_counter.sv | 30 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: memory status encoding, arbiter
// FSM states and the grant-owner encoding used by the tie-break register.
package cpu_types_pkg;

    // Memory controller status, as presented on ramstate.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IACC  = 2'd1,
        DACC  = 2'd2,
        FAULT = 2'd3
    } arb_state_t;

    // Owner of the most recent grant; instruction is the reset owner so the
    // data port wins the first tie.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // True while the FSM owns the memory bus.
    function automatic logic is_access(input arb_state_t st);
        return (st == IACC) || (st == DACC);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-cycle counter for a pending memory access. Clears on every grant,
// counts cycles the memory is not ready and flags the terminal count at
// TIMEOUT_CYC-1, where it holds until cleared.
module wait_counter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_reg;

    // Count stalled cycles; saturate at the terminal value.
    always_ff @(posedge CLK) begin
        if (!nRST || clear) begin
            count_reg <= '0;
        end else if (enable && !tc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single memory port.
// One access in flight at a time; alternating priority on ties; a timeout
// or memory error parks the FSM in FAULT until reset.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int AW          = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    // instruction port
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          ihit,
    output logic [AW-1:0] iload,
    // data port
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [AW-1:0] dstore,
    output logic          dhit,
    output logic [AW-1:0] dload,
    // memory port
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [AW-1:0] ramstore,
    input  logic [AW-1:0] ramload,
    input  logic [1:0]    ramstate,
    // status
    output logic          err
);

    arb_state_t    state_reg, state_next;
    ramstate_t     rs;
    logic          last_grant_reg;
    logic [AW-1:0] addr_reg, store_reg;
    logic          wr_reg;
    logic [AW-1:0] iload_reg, dload_reg;
    logic          ihit_reg, dhit_reg;

    logic d_req;
    logic grant_i, grant_d;
    logic mem_done;
    logic tc;
    logic cnt_enable;

    assign rs    = ramstate_t'(ramstate);
    assign d_req = dREN | dWEN;

    // Grant decision: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_reg == IDLE) begin
            grant_d = d_req && (!iREN || (last_grant_reg == GRANT_I));
            grant_i = iREN  && (!d_req || (last_grant_reg == GRANT_D));
        end
    end

    assign mem_done   = is_access(state_reg) && (rs == ACCESS);
    assign cnt_enable = is_access(state_reg) && ((rs == BUSY) || (rs == FREE));

    wait_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wait_counter (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (grant_i | grant_d),
        .enable (cnt_enable),
        .tc     (tc)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; ACCESS on the terminal cycle still completes.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_d)      state_next = DACC;
                else if (grant_i) state_next = IACC;
            end
            IACC, DACC: begin
                if (rs == ACCESS)               state_next = IDLE;
                else if ((rs == ERROR) || tc)   state_next = FAULT;
            end
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // Request latches, tie-break owner, read data capture and hit pulses.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            last_grant_reg <= GRANT_I;
            addr_reg       <= '0;
            store_reg      <= '0;
            wr_reg         <= 1'b0;
            iload_reg      <= '0;
            dload_reg      <= '0;
            ihit_reg       <= 1'b0;
            dhit_reg       <= 1'b0;
        end else begin
            ihit_reg <= mem_done && (state_reg == IACC);
            dhit_reg <= mem_done && (state_reg == DACC);
            if (grant_d) begin
                last_grant_reg <= GRANT_D;
                addr_reg       <= daddr;
                store_reg      <= dstore;
                // a simultaneous read+write request is treated as a write
                wr_reg         <= dWEN;
            end else if (grant_i) begin
                last_grant_reg <= GRANT_I;
                addr_reg       <= iaddr;
                store_reg      <= '0;
                wr_reg         <= 1'b0;
            end
            if (mem_done && (state_reg == IACC)) begin
                iload_reg <= ramload;
            end
            if (mem_done && (state_reg == DACC) && !wr_reg) begin
                dload_reg <= ramload;
            end
        end
    end

    // Memory-side outputs come only from the latches, and only while accessing.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        err      = (state_reg == FAULT);
        case (state_reg)
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = addr_reg;
            end
            DACC: begin
                ramREN   = !wr_reg;
                ramWEN   = wr_reg;
                ramaddr  = addr_reg;
                ramstore = store_reg;
            end
            default: ;
        endcase
    end

    assign ihit  = ihit_reg;
    assign dhit  = dhit_reg;
    assign iload = iload_reg;
    assign dload = dload_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions with
// hand-computed results, then tie, timeout, error and reset sequences.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN, dREN, dWEN;
    logic [AW-1:0] iaddr, daddr, dstore;
    logic          ihit, dhit;
    logic [AW-1:0] iload, dload;
    logic          ramREN, ramWEN;
    logic [AW-1:0] ramaddr, ramstore, ramload;
    logic [1:0]    ramstate;
    logic          err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT_CYC(TO), .AW(AW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end (got running, need finished)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        is_inst;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        int          busy;
        logic [31:0] rload;
        logic        exp_wr;
        logic [31:0] exp_iload;
        logic [31:0] exp_dload;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, need 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Caller is #1 after a posedge; leaves at #1 after the edge closing reset.
    task automatic do_reset();
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = 2'd0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ihit"},   32'(ihit),   32'd0);
        check({tag, "_dhit"},   32'(dhit),   32'd0);
        check({tag, "_err"},    32'(err),    32'd0);
        check({tag, "_ramREN"}, 32'(ramREN), 32'd0);
        check({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
        check({tag, "_ramaddr"}, ramaddr,    32'd0);
        check({tag, "_iload"},  iload,       32'd0);
        check({tag, "_dload"},  dload,       32'd0);
    endtask

    // One transaction; the request appears in cycle 0, the memory answers
    // BUSY for v.busy strobed cycles and then ACCESS.
    task automatic run_txn(input vec_t v, input string tag);
        int   cyc = 0;
        int   strobes = 0;
        int   hit_cyc = -1;
        bit   port_ok = 1'b0;
        bit   op_ok = 1'b1;
        iREN  = v.is_inst;
        dREN  = v.is_inst ? 1'b0 : v.ren;
        dWEN  = v.is_inst ? 1'b0 : v.wen;
        iaddr = v.addr;
        daddr = v.addr;
        dstore = v.store;
        ramstate = 2'd0;
        while (hit_cyc < 0 && cyc < 30) begin
            @(posedge CLK); #1;
            cyc++;
            if (ihit || dhit) begin
                hit_cyc = cyc;
                port_ok = v.is_inst ? (ihit && !dhit) : (dhit && !ihit);
                iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
                ramstate = 2'd0;
            end else if (ramREN || ramWEN) begin
                strobes++;
                if (ramaddr !== v.addr) op_ok = 1'b0;
                if (v.is_inst && (ramREN !== 1'b1 || ramWEN !== 1'b0)) op_ok = 1'b0;
                if (!v.is_inst && (ramWEN !== v.exp_wr || ramREN !== !v.exp_wr)) op_ok = 1'b0;
                if (!v.is_inst && v.exp_wr && ramstore !== v.store) op_ok = 1'b0;
                ramstate = (strobes <= v.busy) ? 2'd1 : 2'd2;
                ramload  = v.rload;
            end else begin
                ramstate = 2'd0;
            end
        end
        check({tag, "_hit_cycle"}, 32'(hit_cyc), 32'(v.busy + 2));
        check({tag, "_hit_port"},  32'(port_ok), 32'd1);
        check({tag, "_strobes"},   32'(strobes), 32'(v.busy + 1));
        check({tag, "_ram_op"},    32'(op_ok),   32'd1);
        check({tag, "_iload"},     iload,        v.exp_iload);
        check({tag, "_dload"},     dload,        v.exp_dload);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t post;
        int   cyc, nh, strobes, hits, err_cyc;

        //          inst  ren   wen   addr         store        busy rload        wr    iload        dload
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h100,     32'h0,       0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h40,      32'h12345678, 3, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h80,      32'h0,       1, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h44,      32'hA5A5A5A5, 0, 32'h11111111, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h104,     32'h0,       2, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'hFC,      32'h0,       3, 32'h13579BDF, 1'b0, 32'h0BADF00D, 32'h13579BDF};

        nRST = 1'b0;
        @(posedge CLK); #1;
        do_reset();
        check_reset_state("rst0");

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        do_reset();
        check_reset_state("rst1");

        // Both ports held continuously: grants alternate data, inst, data, inst.
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h400; daddr = 32'h500;
        cyc = 0; nh = 0;
        while (nh < 4 && cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
            if (ihit && dhit) check("tie_both_hits", 32'd1, 32'd0);
            if (ihit || dhit) begin
                check($sformatf("tie%0d_port_is_data", nh), 32'(dhit), ((nh % 2) == 0) ? 32'd1 : 32'd0);
                check($sformatf("tie%0d_cycle", nh), 32'(cyc), 32'(2 * (nh + 1)));
                nh++;
            end
            ramstate = (ramREN || ramWEN) ? 2'd2 : 2'd0;
        end
        check("tie_hit_count", 32'(nh), 32'd4);

        // Memory stuck BUSY: four strobed cycles, then FAULT with no hit.
        do_reset();
        dREN = 1'b1; daddr = 32'h200; ramstate = 2'd1;
        strobes = 0; hits = 0; err_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge CLK); #1;
            if (ramREN || ramWEN) strobes++;
            if (ihit || dhit) hits++;
            if (err && err_cyc == 0) err_cyc = c;
        end
        check("timeout_strobes", 32'(strobes), 32'd4);
        check("timeout_err_cycle", 32'(err_cyc), 32'd5);
        check("timeout_hits", 32'(hits), 32'd0);
        dREN = 1'b0; iREN = 1'b1; iaddr = 32'h204; ramstate = 2'd2;
        strobes = 0; hits = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK); #1;
            if (ramREN || ramWEN) strobes++;
            if (ihit || dhit) hits++;
        end
        check("fault_ignores_strobes", 32'(strobes), 32'd0);
        check("fault_ignores_hits", 32'(hits), 32'd0);
        check("fault_err_sticky", 32'(err), 32'd1);
        do_reset();
        check_reset_state("rst2");

        // ramstate ERROR during an access faults on the next cycle.
        dREN = 1'b1; daddr = 32'h600;
        @(posedge CLK); #1;
        check("error_strobe", 32'(ramREN), 32'd1);
        ramstate = 2'd3;
        @(posedge CLK); #1;
        check("error_err", 32'(err), 32'd1);
        check("error_no_dhit", 32'(dhit), 32'd0);
        check("error_strobe_off", 32'(ramREN), 32'd0);

        // Reset during an instruction wait aborts it silently.
        do_reset();
        iREN = 1'b1; iaddr = 32'h300; ramstate = 2'd1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("abort_wait_strobe", 32'(ramREN), 32'd1);
        nRST = 1'b0; iREN = 1'b0;
        @(posedge CLK); #1;
        check("abort_ramREN", 32'(ramREN), 32'd0);
        check("abort_ihit", 32'(ihit), 32'd0);
        nRST = 1'b1; ramstate = 2'd2;
        hits = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            if (ihit || dhit) hits++;
        end
        check("abort_no_late_hit", 32'(hits), 32'd0);
        post = '{1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 1, 32'h55AA55AA, 1'b0, 32'h55AA55AA, 32'h0};
        run_txn(post, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
